countdown_timer: RTL

Programmable down-counter: the decrementing counterpart of the team's free-running 4-bit up-counter. It is loaded with a start value, counts down to zero at a prescaled rate, and pulses `done` on reaching zero. An optional auto-reload mode turns it into a periodic tick generator. Used wherever a block needs a fixed-length wait or a periodic strobe rather than a running count.

---
 rtl/countdown_timer.sv | 105 ++++++++++
 1 files changed

// File: rtl/countdown_timer.sv
// Programmable down-counter with prescaler, one-shot or auto-reload modes.
// Pulses done on reaching zero; busy is high while counting.
module countdown_timer #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] reload;
    logic [PW-1:0]    presc;
    logic             tick;
    logic             terminal;

    assign tick     = (presc == LAST);
    assign terminal = (q <= WIDTH'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            q      <= '0;
            reload <= '0;
            presc  <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                q      <= load_value;
                reload <= load_value;
                presc  <= '0;
                state  <= IDLE;
                busy   <= 1'b0;
            end else if (stop) begin
                if (state == RUN) begin
                    state <= IDLE;
                    presc <= '0;
                    busy  <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start && q != '0) begin
                            state <= RUN;
                            presc <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    EXPIRED: begin
                        if (start && reload != '0) begin
                            q     <= reload;
                            state <= RUN;
                            presc <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!tick) begin
                            presc <= presc + PW'(1);
                        end else begin
                            presc <= '0;
                            if (!terminal) begin
                                q <= q - WIDTH'(1);
                            end else begin
                                // terminal tick: reload keeps running, else expire at zero
                                done <= 1'b1;
                                if (auto_reload) begin
                                    q <= reload;
                                end else begin
                                    q     <= '0;
                                    state <= EXPIRED;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
